led_indicator: RTL and testbench
================================

LED_INDICATOR -- requirements
Module: led_indicator

Interface
REQ-001 SHALL have parameter WIDTH, default 1: number of independent indicator channels.
REQ-002 SHALL have parameter RATE, default 125000: clock division factor; one tick every RATE+1 clk cycles (24-bit counter).
REQ-003 SHALL have parameter ON_TICKS, default 4: minimum ticks an activity flash stays lit (1..255).
REQ-004 SHALL have parameter OFF_TICKS, default 4: minimum dark ticks after an activity flash (1..255).
REQ-005 SHALL have parameter BLINK_TICKS, default 8: ticks per blink half-period (1..255).
REQ-006 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port mode, input, 2*WIDTH bits: channel k mode is mode[2k+1:2k]; 00 off, 01 on, 10 blink, 11 activity.
REQ-009 SHALL have port event, input, WIDTH bits: per-channel activity strobe, sampled every clk, level or pulse.
REQ-010 SHALL have port out, output, WIDTH bits: registered indicator drive, 1 = lit.

Function
REQ-011 SHALL run a prescaler cnt: 0..RATE, wrapping RATE->0; tick is high for one cycle when cnt==RATE.
REQ-012 SHALL keep a shared blink counter and phase bit; on each tick the counter increments; when it reaches BLINK_TICKS-1 on a tick, it clears and phase toggles.
REQ-013 SHALL drive out[k] one cycle after the inputs: mode 00 -> 0; 01 -> 1; 10 -> phase; 11 -> 1 iff channel FSM in ON.
REQ-014 SHALL give each channel an activity FSM with states IDLE, ON, HOLD, an 8-bit tick counter, and a pending bit.
REQ-015 IDLE: event[k]=1 with mode 11 -> ON, counter loaded ON_TICKS; tick in the same cycle is not counted.
REQ-016 ON: each tick decrements the counter; a tick with counter==1 -> HOLD, counter loaded OFF_TICKS; events in ON are absorbed (no pending set).
REQ-017 HOLD: event[k]=1 sets pending; each tick decrements; a tick with counter==1 -> ON (reload ON_TICKS, clear pending) if pending or event this cycle, else IDLE.
REQ-018 SHALL keep the lit time of a flash between (ON_TICKS-1)*(RATE+1)+1 and ON_TICKS*(RATE+1) cycles; dark time between flashes follows the same rule with OFF_TICKS.
REQ-019 Mode of channel k != 11: that FSM forced to IDLE, counter 0, pending 0 on the next edge; re-entering 11 starts from IDLE.
REQ-020 Channels SHALL be fully independent except for the shared prescaler and blink phase; blinking channels are in phase.
REQ-021 Prescaler and blink counter SHALL run continuously regardless of mode.

Reset
REQ-022 rst=1 at a clk edge SHALL set cnt=0, blink counter=0, phase=0, all FSMs IDLE, counters 0, pending 0, out=0.
REQ-023 rst asserted mid-flash SHALL drop out to 0 on that edge; no flash resumes after release without a new event.
REQ-024 First tick after rst release SHALL occur RATE+1 cycles after the release edge.

Verification
REQ-025 Bench params: WIDTH=2, RATE=3, ON_TICKS=2, OFF_TICKS=1, BLINK_TICKS=2; tick every 4 cycles.
REQ-026 Mode 10 on ch0 after reset -> out[0]=0 for 8 cycles, then 1 for 8, periodic; phase toggles on every 2nd tick.
REQ-027 Mode 11, one-cycle event in IDLE -> out high the next cycle; lit 5..8 cycles; then HOLD dark 1..4 cycles; then IDLE.
REQ-028 Mode 11, event held high continuously -> repeating 2-tick-lit / 1-tick-dark pattern; never stuck lit.
REQ-029 Event during HOLD -> second flash starts at HOLD expiry tick; event during ON -> no second flash.
REQ-030 Mode switched 11->00 mid-ON, then back to 11 with no event -> out 0 next cycle and remains 0; rst mid-ON -> out 0 next edge, counters cleared.

Source files
------------

// File: rtl/led_indicator.sv
// LED indicator driver: shared prescaler and blink phase, one activity-flash
// FSM per channel. Channel k mode: 00 off, 01 on, 10 blink, 11 activity.
// evt: per-channel activity strobe, level or pulse.
module led_indicator #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned RATE        = 125000,
  parameter int unsigned ON_TICKS    = 4,
  parameter int unsigned OFF_TICKS   = 4,
  parameter int unsigned BLINK_TICKS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*WIDTH-1:0]   mode,
  input  logic [WIDTH-1:0]     evt,
  output logic [WIDTH-1:0]     out
);

  localparam logic [23:0] RATE_C      = 24'(RATE);
  localparam logic [7:0]  ON_C        = 8'(ON_TICKS);
  localparam logic [7:0]  OFF_C       = 8'(OFF_TICKS);
  localparam logic [7:0]  BLINK_LAST  = 8'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    HOLD
  } act_state_t;

  logic [23:0] cnt;
  logic        tick;
  logic [7:0]  blink_cnt;
  logic [7:0]  blink_cnt_n;
  logic        phase;
  logic        phase_n;

  act_state_t  state   [WIDTH];
  act_state_t  state_n [WIDTH];
  logic [7:0]  tcnt    [WIDTH];
  logic [7:0]  tcnt_n  [WIDTH];
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] pend_n;
  logic [WIDTH-1:0] out_n;

  assign tick = (cnt == RATE_C);

  // Prescaler: counts 0..RATE and wraps, tick on the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 24'd1;
    end
  end

  // Next blink counter/phase; computed ahead so blinking outputs can use it.
  always_comb begin
    blink_cnt_n = blink_cnt;
    phase_n     = phase;
    if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_n = '0;
        phase_n     = ~phase;
      end else begin
        blink_cnt_n = blink_cnt + 8'd1;
      end
    end
  end

  // Shared blink counter and phase registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_n;
      phase     <= phase_n;
    end
  end

  // Activity FSM state, tick counter, pending bit and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < WIDTH; k++) begin
        state[k] <= IDLE;
        tcnt[k]  <= '0;
      end
      pend <= '0;
      out  <= '0;
    end else begin
      for (int unsigned k = 0; k < WIDTH; k++) begin
        state[k] <= state_n[k];
        tcnt[k]  <= tcnt_n[k];
      end
      pend <= pend_n;
      out  <= out_n;
    end
  end

  // Activity FSM next-state: any mode other than 11 parks the channel in IDLE.
  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    pend_n  = pend;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (mode[2*k +: 2] != 2'b11) begin
        state_n[k] = IDLE;
        tcnt_n[k]  = '0;
        pend_n[k]  = 1'b0;
      end else begin
        case (state[k])
          IDLE: begin
            if (evt[k]) begin
              state_n[k] = ON;
              tcnt_n[k]  = ON_C;
            end
          end
          ON: begin
            if (tick) begin
              if (tcnt[k] == 8'd1) begin
                state_n[k] = HOLD;
                tcnt_n[k]  = OFF_C;
              end else begin
                tcnt_n[k] = tcnt[k] - 8'd1;
              end
            end
          end
          HOLD: begin
            pend_n[k] = pend[k] | evt[k];
            if (tick) begin
              if (tcnt[k] == 8'd1) begin
                // An event arriving on the expiry cycle itself still retriggers.
                if (pend[k] | evt[k]) begin
                  state_n[k] = ON;
                  tcnt_n[k]  = ON_C;
                end else begin
                  state_n[k] = IDLE;
                  tcnt_n[k]  = '0;
                end
                pend_n[k] = 1'b0;
              end else begin
                tcnt_n[k] = tcnt[k] - 8'd1;
              end
            end
          end
          default: begin
            state_n[k] = IDLE;
            tcnt_n[k]  = '0;
            pend_n[k]  = 1'b0;
          end
        endcase
      end
    end
  end

  // Output decode from next-state values so out lags the inputs by one cycle.
  always_comb begin
    out_n = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      case (mode[2*k +: 2])
        2'b00:   out_n[k] = 1'b0;
        2'b01:   out_n[k] = 1'b1;
        2'b10:   out_n[k] = phase_n;
        default: out_n[k] = (state_n[k] == ON);
      endcase
    end
  end

endmodule

// File: tb/tb_led_indicator.sv
// Bench for led_indicator: directed flash/blink scenarios with literal
// expectations, plus randomized traffic against a cycle-count-based model.
module tb_led_indicator;

  localparam int W     = 2;
  localparam int RATE  = 3;
  localparam int ONT   = 2;
  localparam int OFFT  = 1;
  localparam int BLINK = 2;

  logic           clk;
  logic           rst;
  logic [2*W-1:0] mode;
  logic [W-1:0]   evt;
  logic [W-1:0]   out;

  int total = 0;
  int bad   = 0;

  led_indicator #(
    .WIDTH      (W),
    .RATE       (RATE),
    .ON_TICKS   (ONT),
    .OFF_TICKS  (OFFT),
    .BLINK_TICKS(BLINK)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .evt  (evt),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time since the last reset edge gives tick and phase
  // directly; each activity channel is a remaining-lit / remaining-dark count.
  bit          m_valid = 1'b0;
  int unsigned n;
  int          flash [W];
  int          gap   [W];
  bit          pendm [W];
  logic [W-1:0] m_out;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_valid = 1'b1;
        n       = 0;
        m_out   = '0;
        for (int k = 0; k < W; k++) begin
          flash[k] = 0;
          gap[k]   = 0;
          pendm[k] = 1'b0;
        end
      end else if (m_valid) begin
        bit tk;
        bit ph;
        n++;
        tk = (n % (RATE + 1) == 0);
        ph = ((n / ((RATE + 1) * BLINK)) % 2) == 1;
        for (int k = 0; k < W; k++) begin
          logic [1:0] mk;
          mk = mode[2*k +: 2];
          if (mk != 2'b11) begin
            flash[k] = 0;
            gap[k]   = 0;
            pendm[k] = 1'b0;
          end else if (flash[k] > 0) begin
            if (tk) begin
              flash[k]--;
              if (flash[k] == 0) gap[k] = OFFT;
            end
          end else if (gap[k] > 0) begin
            pendm[k] = pendm[k] | evt[k];
            if (tk) begin
              gap[k]--;
              if (gap[k] == 0) begin
                if (pendm[k]) flash[k] = ONT;
                pendm[k] = 1'b0;
              end
            end
          end else if (evt[k]) begin
            flash[k] = ONT;
          end
          case (mk)
            2'b00:   m_out[k] = 1'b0;
            2'b01:   m_out[k] = 1'b1;
            2'b10:   m_out[k] = ph;
            default: m_out[k] = (flash[k] > 0);
          endcase
        end
      end
    end
  end

  // Every-cycle comparison against the model once a reset has been seen.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) chk("model_out", int'(out), int'(m_out));
    end
  end

  task automatic pulse1();
    evt[1] = 1'b1;
    @(negedge clk);
    evt[1] = 1'b0;
  endtask

  // Step until out[1] equals v; cycles = steps taken, or -1 on timeout.
  task automatic wait_out1(input logic v, output int cycles);
    cycles = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out[1] == v) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic count_ones1(input int len, output int ones);
    ones = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (out[1]) ones++;
    end
  endtask

  initial begin
    logic [23:0] pat;
    int c;
    int c2;
    int d;
    int ones;
    int rises;
    int run;
    int max_run;
    logic prev;

    rst  = 1'b1;
    mode = '0;
    evt  = '0;
    repeat (2) @(negedge clk);
    chk("reset_out", int'(out), 0);

    // Blink on ch0 from reset: 8 dark, 8 lit, 8 dark.
    mode = 4'b0010;
    @(negedge clk);
    rst = 1'b0;
    pat = 24'h00FF00;
    chk("blink_0", int'(out[0]), int'(pat[0]));
    for (int i = 1; i < 24; i++) begin
      @(negedge clk);
      chk($sformatf("blink_%0d", i), int'(out[0]), int'(pat[i]));
    end

    // Single activity flash on ch1.
    mode = 4'b1100;
    @(negedge clk);
    pulse1();
    chk("flash_start", int'(out[1]), 1);
    wait_out1(1'b0, c);
    chk("flash_lit_5_8", int'(c >= 5 && c <= 8), 1);

    // Event in the first dark (HOLD) cycle retriggers at HOLD expiry.
    pulse1();
    d = 1;
    c2 = 0;
    if (!out[1]) begin
      wait_out1(1'b1, c2);
      d = 1 + c2;
    end
    chk("hold_relit", int'(c2 >= 0), 1);
    chk("hold_dark_1_4", int'(d >= 1 && d <= 4), 1);

    // Event during ON is absorbed: no further flash after this one.
    @(negedge clk);
    pulse1();
    wait_out1(1'b0, c);
    chk("on_absorb_end", int'(c > 0), 1);
    count_ones1(20, ones);
    chk("on_absorb_dark", ones, 0);

    // Event held high: periodic flashes, never stuck lit.
    evt[1] = 1'b1;
    rises = 0; run = 0; max_run = 0; prev = out[1];
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (out[1] && !prev) rises++;
      run = out[1] ? run + 1 : 0;
      if (run > max_run) max_run = run;
      prev = out[1];
    end
    evt[1] = 1'b0;
    chk("held_rises", int'(rises >= 4), 1);
    chk("held_max_lit", int'(max_run >= 5 && max_run <= 8), 1);
    count_ones1(24, ones);
    chk("held_release_done", int'(out[1]), 0);

    // Mode 11 -> 00 mid-flash, then back to 11 with no event.
    pulse1();
    chk("mode_sw_lit", int'(out[1]), 1);
    mode = 4'b0000;
    @(negedge clk);
    chk("mode_sw_off", int'(out[1]), 0);
    mode = 4'b1100;
    count_ones1(20, ones);
    chk("mode_sw_stays_dark", ones, 0);

    // Reset mid-flash.
    pulse1();
    chk("rst_flash_lit", int'(out[1]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_on", int'(out), 0);
    rst = 1'b0;
    count_ones1(20, ones);
    chk("rst_no_resume", ones, 0);

    // Randomized traffic, checked every cycle by the model process.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 0) mode = '1;
        else mode = 4'($urandom);
      end
      for (int k = 0; k < W; k++)
        if ($urandom_range(0, 5) == 0) evt[k] = ~evt[k];
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    evt = '0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
